// File: rtl/uart_rx_dac.sv
// UART (8N1, LSB first) sample receiver feeding a small FIFO that is replayed to an AD9708 DAC.
// Define UART_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_dac #(
    parameter int unsigned CLK_FRE    = 50,
    parameter int unsigned UART_RATE  = 115200,
    parameter int unsigned DAC_FRE    = 500,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] ad9708_db,
    output logic       ad9708_clk,
    output logic       rx_err,
    output logic       fifo_ovf
);

    localparam int unsigned BIT_CYC  = CLK_FRE * 1000000 / UART_RATE;
    localparam int unsigned DAC_DIV  = CLK_FRE * 1000 / DAC_FRE;
    localparam int unsigned DAC_HALF = DAC_DIV / 2;
    localparam int unsigned BCW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int unsigned DCW      = (DAC_DIV > 1) ? $clog2(DAC_DIV) : 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned PW       = AW + 1;

    localparam logic [BCW-1:0] HALF_M1 = BCW'(BIT_CYC / 2 - 1);
    localparam logic [BCW-1:0] FULL_M1 = BCW'(BIT_CYC - 1);
    localparam logic [DCW-1:0] UPD_PT  = DCW'(DAC_HALF - 1);
    localparam logic [DCW-1:0] DCNT_MX = DCW'(DAC_DIV - 1);
    localparam logic [DCW-1:0] DHALF   = DCW'(DAC_HALF);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } rx_state_t;
`endif

    // ---------------------------------------------------------------
    // Input synchronizer; rx_s3 only serves falling-edge detection
    // ---------------------------------------------------------------
    logic rx_s1;
    logic rx_s2;
    logic rx_s3;
    logic fall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign fall_c = rx_s3 & ~rx_s2;

    // ---------------------------------------------------------------
    // RX FSM
    // ---------------------------------------------------------------
    rx_state_t      state;
    rx_state_t      state_nxt;
    logic [BCW-1:0] cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           half_hit_c;
    logic           full_hit_c;
    logic           cnt_clr_c;
    logic           idle_c;
    logic           shift_c;
    logic           push_c;
    logic           err_c;
`ifdef UART_PARITY_EN
    logic           par_c;
    logic           par_bad;
`endif

    assign half_hit_c = (cnt == HALF_M1);
    assign full_hit_c = (cnt == FULL_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fall_c) state_nxt = S_START;
            S_START:  if (half_hit_c) state_nxt = rx_s2 ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:   if (full_hit_c && (bit_idx == 3'd7)) state_nxt = S_PARITY;
            S_PARITY: if (full_hit_c) state_nxt = S_STOP;
`else
            S_DATA:   if (full_hit_c && (bit_idx == 3'd7)) state_nxt = S_STOP;
`endif
            S_STOP:   if (full_hit_c) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Sampling strobes: start bit at half a bit, every later bit one full bit after that
    always_comb begin
        cnt_clr_c = 1'b0;
        idle_c    = 1'b0;
        shift_c   = 1'b0;
        push_c    = 1'b0;
        err_c     = 1'b0;
`ifdef UART_PARITY_EN
        par_c     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_clr_c = 1'b1;
                idle_c    = 1'b1;
            end
            S_START: cnt_clr_c = half_hit_c;
            S_DATA: begin
                cnt_clr_c = full_hit_c;
                shift_c   = full_hit_c;
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                cnt_clr_c = full_hit_c;
                par_c     = full_hit_c;
            end
`endif
            S_STOP: begin
                if (full_hit_c) begin
                    cnt_clr_c = 1'b1;
`ifdef UART_PARITY_EN
                    if (rx_s2 && !par_bad) push_c = 1'b1;
                    else                   err_c  = 1'b1;
`else
                    if (rx_s2) push_c = 1'b1;
                    else       err_c  = 1'b1;
`endif
                end
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

    // Bit timing counter, shift register and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            rx_err  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            cnt    <= cnt_clr_c ? '0 : cnt + BCW'(1);
            rx_err <= err_c;
            if (idle_c) begin
                bit_idx <= 3'd0;
            end else if (shift_c) begin
                bit_idx <= bit_idx + 3'd1;
                shreg   <= {rx_s2, shreg[7:1]};
            end
`ifdef UART_PARITY_EN
            if (idle_c) begin
                par_bad <= 1'b0;
            end else if (par_c) begin
                par_bad <= (^shreg) ^ rx_s2;
            end
`endif
        end
    end

    // ---------------------------------------------------------------
    // Sample FIFO (extra pointer bit distinguishes full from empty)
    // ---------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full_c;
    logic          empty_c;
    logic          pop_c;
    logic          wr_c;
    logic          upd_c;

    assign empty_c = (wptr == rptr);
    assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_c   = upd_c && !empty_c;
    assign wr_c    = push_c && (!full_c || pop_c);

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wptr[AW-1:0]] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (wr_c) wptr <= wptr + PW'(1);
            if (pop_c) rptr <= rptr + PW'(1);
            if (push_c && full_c && !pop_c) fifo_ovf <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // DAC pacing: data moves on the falling DAC clock edge only
    // ---------------------------------------------------------------
    logic [DCW-1:0] dcnt;
    logic [DCW-1:0] dcnt_nxt_c;

    assign dcnt_nxt_c = (dcnt == DCNT_MX) ? '0 : dcnt + DCW'(1);
    assign upd_c      = (dcnt == UPD_PT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt       <= '0;
            ad9708_clk <= 1'b0;
            ad9708_db  <= 8'h80;
        end else begin
            dcnt       <= dcnt_nxt_c;
            ad9708_clk <= (dcnt_nxt_c < DHALF);
            if (pop_c) ad9708_db <= mem[rptr[AW-1:0]];
        end
    end

endmodule

// File: doc/uart_rx_dac.md
Name: uart_rx_dac

Overview:
- Reverse path of the ADC-to-UART capture chain: receives 8-bit samples over UART (8N1, LSB first) and buffers them in a small FIFO.
- Replays the buffered samples to an AD9708 8-bit parallel DAC at a fixed update rate.
- Sits at top level beside the ADC capture path; shares the board clock and rst_n.

Parameters:
CLK_FRE, 50, input clock in MHz
UART_RATE, 115200, baud rate; BIT_CYC = CLK_FRE*1000000/UART_RATE (434 at defaults)
DAC_FRE, 500, DAC update rate in kHz; DAC_DIV = CLK_FRE*1000/DAC_FRE (100 at defaults), must be even and >= 4
FIFO_DEPTH, 16, sample buffer depth, power of two

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial input, idle high, asynchronous to clk
ad9708_db  out  8  DAC data, straight binary
ad9708_clk  out  1  DAC clock; DAC latches on rising edge
rx_err  out  1  one-cycle pulse on a framing or parity error
fifo_ovf  out  1  sticky; set when a received byte is dropped because the FIFO is full

Behaviour:
- Reset values:
  - ad9708_db = 8'h80 (midscale).
  - ad9708_clk = 0, rx_err = 0, fifo_ovf = 0.
  - FIFO empty; RX FSM in IDLE; all counters 0.
  - Reset mid-frame aborts the frame; no partial byte is pushed.
- RX input: uart_rx passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- RX FSM (bit counter runs 0..BIT_CYC-1):
  - IDLE: on a synchronized falling edge, clear the counter and go to START.
  - START: at count BIT_CYC/2-1 sample the line.
    - Low: go to DATA with bit index 0.
    - High: false start, return to IDLE with no error.
  - DATA: sample once per BIT_CYC at mid-bit, shift in LSB first. After bit 7, go to STOP.
  - STOP: sample at mid-bit.
    - High: push the byte.
    - Low: pulse rx_err for 1 cycle and drop the byte.
    - In both cases return to IDLE in the same cycle, so back-to-back frames resync on the next falling edge.
- FIFO:
  - Synchronous, not first-word-fall-through.
  - A push when full drops the byte and sets fifo_ovf. fifo_ovf clears only on reset.
  - Push while full in the same cycle as a pop: the push is accepted and fifo_ovf is not set.
  - Push into an empty FIFO is not poppable until the following cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- DAC side:
  - Free-running counter dcnt, 0..DAC_DIV-1.
  - ad9708_clk is registered: 1 while dcnt < DAC_DIV/2, else 0.
  - Update point is the edge where dcnt becomes DAC_DIV/2 (ad9708_clk falls).
    - FIFO non-empty: pop the head and register it on ad9708_db.
    - FIFO empty: ad9708_db holds its last value (no underrun flag).
  - Data therefore changes only on the falling edge and is stable for DAC_DIV/2 cycles before the rising edge.
- Latency:
  - Push occurs at the stop-bit mid-sample edge.
  - With the FIFO empty beforehand, ad9708_db updates at the first update point at least 1 cycle after the push: worst case DAC_DIV+1 cycles.
  - The sample is latched by the DAC DAC_DIV/2 cycles after that.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Frame is 8E1. An even-parity bit is sampled at mid-bit in a PARITY state between DATA and STOP.
  - On parity mismatch: rx_err pulses at the stop sample and the byte is dropped, even if the stop bit is valid.
  - A frame with both bad parity and a bad stop bit gives a single rx_err pulse.
- Undefined: 8N1 as above; the PARITY state does not exist.

Test Plan:
- Reset, then idle for 1000 cycles -> ad9708_db=0x80; ad9708_clk toggles with period 100 and 50% duty; rx_err=0; fifo_ovf=0.
- Send 0x5A at 115200 -> ad9708_db=0x5A within 101 cycles of the stop-bit mid-sample, changing only on a ad9708_clk falling edge; holds 0x5A thereafter.
- Send 0x00, 0xFF, 0x33 back-to-back -> ad9708_db shows 0x00, 0xFF, 0x33 in order, each at a separate update point.
- DAC_FRE=1 (DAC_DIV=50000); send 20 bytes 0x01..0x14 back-to-back -> fifo_ovf rises on the 17th byte if no pop has occurred yet; output sequence has no gaps up to the last stored byte.
- Send 0xA5 with the stop bit forced low -> exactly one 1-cycle rx_err pulse; ad9708_db unchanged; the next valid byte 0x3C is received correctly.
- Drive uart_rx low for 100 cycles, then high -> no push, no rx_err. Assert rst_n low mid-frame -> outputs return to reset values; the next full frame is received.
